fft_twiddle_seq: RTL
====================

# fft_twiddle_seq

Twiddle-fetch sequencer for the radix-2 DIT FFT butterfly datapath. It is the read-side master of the synchronous twiddle ROM. It walks every stage and butterfly of a 2^LOG2N-point transform and drives the ROM address. It captures the ROM's registered real/imaginary output one cycle later and presents {twiddle, operand indices, stage} to the butterfly unit over a valid/ready handshake.

## Interface
- LOG2N, 3, log2 of transform size (N = 8 default); ROM depth is N
- DW, 8, twiddle component width (signed Q1.(DW-1))
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a transform; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final butterfly handshake
- tw_addr  out  LOG2N  registered ROM address
- tw_re_in  in  DW  ROM real output (valid one cycle after tw_addr is sampled)
- tw_im_in  in  DW  ROM imaginary output
- out_valid  out  1  butterfly descriptor valid
- out_ready  in  1  butterfly unit accepts descriptor
- tw_re, tw_im  out  DW each  captured twiddle
- idx_a, idx_b  out  LOG2N each  butterfly operand indices
- stage  out  clog2(LOG2N)  current stage number

## Operation
- Counters: stage s in 0..LOG2N-1 and butterfly j in 0..N/2-1; total LOG2N*N/2 descriptors (12 for N=8).
- half = 2^s, pos = j mod half, grp = j >> s.
- tw_addr = pos << (LOG2N-1-s). Only indices 0..N/2-1 are ever issued.
- idx_a = grp*2*half + pos, idx_b = idx_a + half.
- N=8 stage 0 pairs: (0,1)(2,3)(4,5)(6,7).
- N=8 stage 1 pairs: (0,2)(1,3)(4,6)(5,7).
- N=8 stage 2 pairs: (0,4)(1,5)(2,6)(3,7).
- Order: j increments fastest; on j wrap, s increments.
- FSM:
  - IDLE: start=1 → clear s and j, tw_addr<=0, busy<=1 → ISSUE.
  - ISSUE: ROM samples tw_addr at this edge → CAPTURE.
  - CAPTURE: tw_re<=tw_re_in, tw_im<=tw_im_in; idx_a, idx_b and stage loaded from counters; out_valid<=1 → VALID.
  - VALID, out_ready=0: all outputs held stable, including tw_addr.
  - VALID, out_ready=1, not last: out_valid<=0, advance counters, tw_addr<=next index → ISSUE.
  - VALID, out_ready=1, last (s=LOG2N-1, j=N/2-1): out_valid<=0, busy<=0, done<=1 → IDLE.
- start outside IDLE is ignored. start asserted in the same cycle done pulses is also ignored; start is accepted from the following cycle.
- The descriptor only changes after a handshake, so the ROM output is never sampled mid-change.

## Timing
- Reset values: busy=0, done=0, out_valid=0, tw_addr=0, tw_re=0, tw_im=0, idx_a=0, idx_b=0, stage=0, FSM=IDLE.
- Reset asserted mid-transform aborts immediately to reset values. No done pulse is generated.
- Start-to-first-valid: start accepted at edge E0 → out_valid high after E2 (2-cycle latency).
- Handshake-to-next-valid: accepted at edge Ek → next out_valid high after Ek+2. Peak throughput is one descriptor per 3 cycles.
- Minimum transform length with out_ready tied high is 36 cycles from start acceptance to done for N=8.
- done is high exactly one cycle, in the cycle after the last handshake edge.

## Configuration
- FFT_TWIDDLE_CONJ_EN defined: tw_im is the negated tw_im_in, for inverse-FFT use.
  - Negation saturates: -(−2^(DW-1)) = 2^(DW-1)−1, e.g. 8'h80 → 8'h7F.
  - tw_re is unchanged.
- FFT_TWIDDLE_CONJ_EN undefined: tw_im = tw_im_in captured verbatim.

## Test plan
- Reset, then start pulse, out_ready=1 → 12 descriptors in order. Stage 0: tw_addr 0,0,0,0. Stage 1: 0,2,0,2. Stage 2: 0,1,2,3. idx pairs as listed under Operation. done at cycle 36; busy low after done.
- ROM model with index 2 = (8'h00, 8'h80) → stage 1, j=1 descriptor carries tw_re=8'h00, tw_im=8'h80. With FFT_TWIDDLE_CONJ_EN defined, tw_im=8'h7F.
- Hold out_ready=0 for 10 cycles at the 5th descriptor → out_valid stays 1. tw_re, tw_im, idx_a, idx_b, stage and tw_addr are unchanged throughout. On release, the 6th descriptor appears 2 cycles after the handshake.
- Pulse start while busy, and again in the done cycle → both ignored; exactly 12 descriptors and one done pulse. A start one cycle later begins a new transform.
- Assert rst_n=0 during the 7th VALID → all outputs return to reset values asynchronously and no done pulse occurs. A fresh start then produces the full 12-descriptor sequence from stage 0, j=0.
- Random out_ready (50%) → the descriptor sequence is identical to the ready-tied-high run, and done pulses exactly once.

Source files
------------

// File: rtl/fft_twiddle_seq_if.sv
// Butterfly descriptor handshake bundle for fft_twiddle_seq.
// master drives the descriptor, slave returns out_ready.
interface fft_twiddle_seq_if #(
  parameter int LOG2N = 3,
  parameter int DW    = 8
);
  localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;

  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    tw_re;
  logic [DW-1:0]    tw_im;
  logic [LOG2N-1:0] idx_a;
  logic [LOG2N-1:0] idx_b;
  logic [SW-1:0]    stage;

  modport master (
    output out_valid,
    output tw_re,
    output tw_im,
    output idx_a,
    output idx_b,
    output stage,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  tw_re,
    input  tw_im,
    input  idx_a,
    input  idx_b,
    input  stage,
    output out_ready
  );
endinterface

// File: rtl/fft_twiddle_seq.sv
// Radix-2 DIT twiddle-fetch sequencer: walks stages/butterflies, reads ROM.
// FFT_TWIDDLE_CONJ_EN: capture saturated -tw_im_in (inverse FFT).
module fft_twiddle_seq #(
  parameter int LOG2N = 3,
  parameter int DW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [LOG2N-1:0] tw_addr,
  input  logic [DW-1:0]    tw_re_in,
  input  logic [DW-1:0]    tw_im_in,
  fft_twiddle_seq_if.master dsc
);
  localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
  localparam int N  = 1 << LOG2N;
  localparam logic [LOG2N-1:0] JMAX  = LOG2N'(N / 2 - 1);
  localparam logic [SW-1:0]    SLAST = SW'(LOG2N - 1);

  typedef enum logic [1:0] {
    IDLE, ISSUE, CAPTURE, VALID
  } state_t;

  state_t state_q, state_d;

  logic [SW-1:0]    s_q;
  logic [LOG2N-1:0] j_q;
  logic             busy_q, done_q, valid_q;
  logic [LOG2N-1:0] addr_q;
  logic [DW-1:0]    re_q, im_q;
  logic [LOG2N-1:0] ia_q, ib_q;
  logic [SW-1:0]    stage_q;

  logic [LOG2N-1:0] half, pos, grp, ia, ib;
  logic [LOG2N-1:0] j_nx, addr_nx;
  logic [SW-1:0]    s_nx;
  logic             last, accept;
  logic [DW-1:0]    im_cap;

  function automatic logic [LOG2N-1:0] addr_of(
    input logic [SW-1:0]    sv,
    input logic [LOG2N-1:0] jv
  );
    logic [LOG2N-1:0] m;
    m = (LOG2N'(1) << sv) - LOG2N'(1);
    return (jv & m) << (SLAST - sv);
  endfunction

  always_comb begin
    half    = LOG2N'(1) << s_q;
    pos     = j_q & (half - LOG2N'(1));
    grp     = j_q >> s_q;
    ia      = ((grp << s_q) << 1) | pos;
    ib      = ia + half;
    last    = (s_q == SLAST) && (j_q == JMAX);
    j_nx    = (j_q == JMAX) ? '0 : j_q + LOG2N'(1);
    s_nx    = (j_q == JMAX) ? s_q + SW'(1) : s_q;
    addr_nx = addr_of(s_nx, j_nx);
  end

`ifdef FFT_TWIDDLE_CONJ_EN
  // Most-negative value has no positive twin; clamp to max.
  always_comb begin
    if (tw_im_in == {1'b1, {(DW-1){1'b0}}})
      im_cap = {1'b0, {(DW-1){1'b1}}};
    else
      im_cap = -tw_im_in;
  end
`else
  always_comb im_cap = tw_im_in;
`endif

  // Start is ignored in the done cycle even though FSM is back in IDLE.
  assign accept = start && !done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = VALID;
      VALID: begin
        if (dsc.out_ready)
          state_d = last ? IDLE : ISSUE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= '0;
      j_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      re_q    <= '0;
      im_q    <= '0;
      ia_q    <= '0;
      ib_q    <= '0;
      stage_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            s_q    <= '0;
            j_q    <= '0;
            addr_q <= '0;
            busy_q <= 1'b1;
          end
        end
        ISSUE: ;
        CAPTURE: begin
          re_q    <= tw_re_in;
          im_q    <= im_cap;
          ia_q    <= ia;
          ib_q    <= ib;
          stage_q <= s_q;
          valid_q <= 1'b1;
        end
        VALID: begin
          if (dsc.out_ready) begin
            valid_q <= 1'b0;
            if (last) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              s_q    <= s_nx;
              j_q    <= j_nx;
              addr_q <= addr_nx;
            end
          end
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign tw_addr       = addr_q;
  assign dsc.out_valid = valid_q;
  assign dsc.tw_re     = re_q;
  assign dsc.tw_im     = im_q;
  assign dsc.idx_a     = ia_q;
  assign dsc.idx_b     = ib_q;
  assign dsc.stage     = stage_q;
endmodule
